drive_pc_seq: RTL and testbench

- Multi-channel program-counter sequencer for the drive circuit; successor to the single-channel drive PC.
- One independent PC per qubit-drive channel.
- Adds explicit start/halt control, absolute jumps, a single-level hardware loop counter per channel, and overflow reporting.
- Keeps the established rule that the first update after a (re)start does not advance the PC.
- Sits between the drive instruction memory address path and the per-channel envelope/NCO controllers.

---
 rtl/drive_pc_pkg.sv | 20 ++
 rtl/drive_pc_ch.sv | 107 ++++++++++
 rtl/drive_pc_seq.sv | 54 +++++
 tb/tb_drive_pc_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/drive_pc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | drive_pc_pkg : shared types and default sizes for the drive PC sequencer  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package drive_pc_pkg;

  localparam int DEF_PC_WIDTH   = 11;
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_LOOP_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } drive_state_e;

endpackage : drive_pc_pkg
`default_nettype wire

// File: rtl/drive_pc_ch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | drive_pc_ch : one drive channel - FSM, PC register, loop counter, flags   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module drive_pc_ch
  import drive_pc_pkg::*;
#(
  parameter int PC_WIDTH   = DEF_PC_WIDTH,
  parameter int LOOP_WIDTH = DEF_LOOP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PC_WIDTH-1:0]   start_pc,
  input  logic                  halt,
  input  logic                  update_pc,
  input  logic                  jump_en,
  input  logic                  loop_back,
  input  logic [PC_WIDTH-1:0]   target_pc,
  input  logic                  loop_load,
  input  logic [LOOP_WIDTH-1:0] loop_count,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  busy,
  output logic                  loop_done,
  output logic                  overflow
);

  localparam logic [LOOP_WIDTH-1:0] C_CNT_ONE = {{(LOOP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PC_WIDTH:0]     C_PC_ONE  = {{PC_WIDTH{1'b0}}, 1'b1};

  drive_state_e          r_state;
  drive_state_e          w_state_nxt;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [PC_WIDTH-1:0]   w_pc_nxt;
  logic [LOOP_WIDTH-1:0] r_cnt;
  logic [LOOP_WIDTH-1:0] w_cnt_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  r_ovf;
  logic                  w_ovf_nxt;
  logic [PC_WIDTH:0]     w_pc_inc;

  // Extra MSB carries the wrap out of the all-ones PC.
  assign w_pc_inc = {1'b0, r_pc} + C_PC_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_ovf_nxt   = r_ovf;

    if (start) begin
      w_state_nxt = ST_PRIME;
      w_pc_nxt    = start_pc;
      w_ovf_nxt   = 1'b0;
    end else if (halt && (r_state == ST_PRIME || r_state == ST_RUN)) begin
      w_state_nxt = ST_DONE;
    end else if (update_pc) begin
      case (r_state)
        ST_PRIME: w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (jump_en) begin
            w_pc_nxt = target_pc;
          end else if (loop_back && (r_cnt != '0)) begin
            w_pc_nxt  = target_pc;
            w_cnt_nxt = r_cnt - C_CNT_ONE;
          end else begin
            w_pc_nxt   = w_pc_inc[PC_WIDTH-1:0];
            w_ovf_nxt  = r_ovf | w_pc_inc[PC_WIDTH];
            w_done_nxt = loop_back;
          end
        end
        default: ;
      endcase
    end

    // A coincident load overrides any decrement; the branch above saw the old count.
    if (loop_load) begin
      w_cnt_nxt = loop_count;
    end
  end

  assign pc        = r_pc;
  assign busy      = (r_state == ST_PRIME) || (r_state == ST_RUN);
  assign loop_done = r_done;
  assign overflow  = r_ovf;

endmodule : drive_pc_ch
`default_nettype wire

// File: rtl/drive_pc_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | drive_pc_seq : multi-channel drive program-counter sequencer             |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module drive_pc_seq
  import drive_pc_pkg::*;
#(
  parameter int PC_WIDTH   = DEF_PC_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int LOOP_WIDTH = DEF_LOOP_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            start,
  input  logic [NUM_CH*PC_WIDTH-1:0]   start_pc,
  input  logic [NUM_CH-1:0]            halt,
  input  logic [NUM_CH-1:0]            update_pc,
  input  logic [NUM_CH-1:0]            jump_en,
  input  logic [NUM_CH-1:0]            loop_back,
  input  logic [NUM_CH*PC_WIDTH-1:0]   target_pc,
  input  logic [NUM_CH-1:0]            loop_load,
  input  logic [NUM_CH*LOOP_WIDTH-1:0] loop_count,
  output logic [NUM_CH*PC_WIDTH-1:0]   pc,
  output logic [NUM_CH-1:0]            busy,
  output logic [NUM_CH-1:0]            loop_done,
  output logic [NUM_CH-1:0]            overflow
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    drive_pc_ch #(
      .PC_WIDTH   (PC_WIDTH),
      .LOOP_WIDTH (LOOP_WIDTH)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .start      (start[c]),
      .start_pc   (start_pc[c*PC_WIDTH +: PC_WIDTH]),
      .halt       (halt[c]),
      .update_pc  (update_pc[c]),
      .jump_en    (jump_en[c]),
      .loop_back  (loop_back[c]),
      .target_pc  (target_pc[c*PC_WIDTH +: PC_WIDTH]),
      .loop_load  (loop_load[c]),
      .loop_count (loop_count[c*LOOP_WIDTH +: LOOP_WIDTH]),
      .pc         (pc[c*PC_WIDTH +: PC_WIDTH]),
      .busy       (busy[c]),
      .loop_done  (loop_done[c]),
      .overflow   (overflow[c])
    );
  end : g_ch

endmodule : drive_pc_seq
`default_nettype wire

// File: tb/tb_drive_pc_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_drive_pc_seq : directed + randomized bench with a behavioural model   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_drive_pc_seq;

  localparam int PCW = 11;
  localparam int NCH = 4;
  localparam int LW  = 8;
  localparam int PC_MOD = 1 << PCW;

  logic               clk = 1'b0;
  logic               rst;
  logic [NCH-1:0]     start, halt, update_pc, jump_en, loop_back, loop_load;
  logic [NCH*PCW-1:0] start_pc, target_pc;
  logic [NCH*LW-1:0]  loop_count;
  logic [NCH*PCW-1:0] pc;
  logic [NCH-1:0]     busy, loop_done, overflow;

  int tests = 0;
  int fails = 0;

  // Model: a channel is either active (accepting halt/updates) or not; an
  // active channel ignores its first update after a start.
  int unsigned m_pc  [NCH];
  int unsigned m_cnt [NCH];
  bit          m_act [NCH];
  bit          m_arm [NCH];
  bit          m_done[NCH];
  bit          m_ovf [NCH];

  drive_pc_seq #(.PC_WIDTH(PCW), .NUM_CH(NCH), .LOOP_WIDTH(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_pc   (start_pc),
    .halt       (halt),
    .update_pc  (update_pc),
    .jump_en    (jump_en),
    .loop_back  (loop_back),
    .target_pc  (target_pc),
    .loop_load  (loop_load),
    .loop_count (loop_count),
    .pc         (pc),
    .busy       (busy),
    .loop_done  (loop_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      if (rst) begin
        m_pc[c] = 0; m_cnt[c] = 0; m_act[c] = 0; m_arm[c] = 0;
        m_done[c] = 0; m_ovf[c] = 0;
      end else begin
        int unsigned old_cnt = m_cnt[c];
        m_done[c] = 0;
        if (start[c]) begin
          m_pc[c] = start_pc[c*PCW +: PCW];
          m_ovf[c] = 0; m_act[c] = 1; m_arm[c] = 0;
        end else if (halt[c] && m_act[c]) begin
          m_act[c] = 0;
        end else if (update_pc[c] && m_act[c]) begin
          if (!m_arm[c]) m_arm[c] = 1;
          else if (jump_en[c]) m_pc[c] = target_pc[c*PCW +: PCW];
          else if (loop_back[c] && old_cnt > 0) begin
            m_pc[c] = target_pc[c*PCW +: PCW];
            m_cnt[c] = old_cnt - 1;
          end else begin
            if (m_pc[c] == PC_MOD - 1) m_ovf[c] = 1;
            m_pc[c] = (m_pc[c] + 1) % PC_MOD;
            m_done[c] = loop_back[c];
          end
        end
        if (loop_load[c]) m_cnt[c] = loop_count[c*LW +: LW];
      end
    end
  endtask

  task automatic clear_strobes();
    rst = 0; start = '0; halt = '0; update_pc = '0; jump_en = '0;
    loop_back = '0; loop_load = '0;
  endtask

  // Advance one clock, update the model with the applied inputs, compare all channels.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("model_pc[%0d]", c), pc[c*PCW +: PCW], m_pc[c]);
      check($sformatf("model_busy[%0d]", c), busy[c], m_act[c]);
      check($sformatf("model_done[%0d]", c), loop_done[c], m_done[c]);
      check($sformatf("model_ovf[%0d]", c), overflow[c], m_ovf[c]);
    end
    clear_strobes();
  endtask

  task automatic set_start(input int c, input int unsigned a);
    start[c] = 1'b1; start_pc[c*PCW +: PCW] = PCW'(a);
  endtask

  task automatic set_target(input int c, input int unsigned a);
    target_pc[c*PCW +: PCW] = PCW'(a);
  endtask

  task automatic set_load(input int c, input int unsigned n);
    loop_load[c] = 1'b1; loop_count[c*LW +: LW] = LW'(n);
  endtask

  function automatic int unsigned pc_of(input int c);
    return pc[c*PCW +: PCW];
  endfunction

  initial begin
    clear_strobes();
    start_pc = '0; target_pc = '0; loop_count = '0;

    // Reset
    rst = 1; tick(); rst = 1; tick();
    check("reset_pc", pc, 0);
    check("reset_busy", busy, 0);
    check("reset_ovf", overflow, 0);

    // Start ch0 at 0x010; first update does not advance
    set_start(0, 'h010); tick();
    check("start_busy0", busy[0], 1);
    update_pc[0] = 1; tick(); check("prime_hold", pc_of(0), 'h010);
    update_pc[0] = 1; tick(); check("run_inc1", pc_of(0), 'h011);
    update_pc[0] = 1; tick(); check("run_inc2", pc_of(0), 'h012);
    check("run_busy0", busy[0], 1);

    // Two jumps back then fall through, with a 4-instruction body
    set_start(0, 'h020); tick();
    update_pc[0] = 1; set_load(0, 2); tick();
    for (int pass = 0; pass < 3; pass++) begin
      update_pc[0] = 1; loop_back[0] = 1; set_target(0, 'h01C); tick();
      if (pass < 2) begin
        check("loop_back_pc", pc_of(0), 'h01C);
        check("loop_no_done", loop_done[0], 0);
        for (int k = 0; k < 4; k++) begin update_pc[0] = 1; tick(); end
      end
    end
    check("loop_exit_pc", pc_of(0), 'h021);
    check("loop_done_pulse", loop_done[0], 1);
    tick();
    check("loop_done_clear", loop_done[0], 0);

    // Jump beats loop and leaves the counter intact (2 -> two more jumps back)
    set_load(0, 2); tick();
    update_pc[0] = 1; jump_en[0] = 1; loop_back[0] = 1; set_target(0, 'h100); tick();
    check("jump_pc", pc_of(0), 'h100);
    update_pc[0] = 1; loop_back[0] = 1; set_target(0, 'h0F0); tick();
    check("cnt_kept1", pc_of(0), 'h0F0);
    update_pc[0] = 1; loop_back[0] = 1; tick();
    check("cnt_kept2", pc_of(0), 'h0F0);
    update_pc[0] = 1; loop_back[0] = 1; tick();
    check("cnt_exhausted", pc_of(0), 'h0F1);

    // Load coinciding with a taken loop-back: load wins
    set_load(0, 1); tick();
    update_pc[0] = 1; loop_back[0] = 1; set_target(0, 'h0A0); set_load(0, 3); tick();
    check("load_coincide_pc", pc_of(0), 'h0A0);

    // Wrap sets sticky overflow; start clears it
    set_start(0, 'h7FF); tick();
    update_pc[0] = 1; tick(); check("wrap_prime", pc_of(0), 'h7FF);
    update_pc[0] = 1; tick();
    check("wrap_pc", pc_of(0), 'h000);
    check("wrap_ovf", overflow[0], 1);
    update_pc[0] = 1; tick(); check("ovf_sticky", overflow[0], 1);
    check("wrap_running", busy[0], 1);
    set_start(0, 'h005); tick(); check("ovf_cleared", overflow[0], 0);

    // start and halt together, then halt mid-run at 0x045
    set_start(0, 'h040); halt[0] = 1; tick();
    check("start_halt_pc", pc_of(0), 'h040);
    check("start_halt_busy", busy[0], 1);
    for (int k = 0; k < 6; k++) begin update_pc[0] = 1; tick(); end
    check("pre_halt_pc", pc_of(0), 'h045);
    halt[0] = 1; tick();
    check("halt_busy", busy[0], 0);
    update_pc[0] = 1; jump_en[0] = 1; set_target(0, 'h300); tick();
    check("done_ignores_upd", pc_of(0), 'h045);

    // ch1 and ch3 run different programs concurrently
    set_start(1, 'h200); set_start(3, 'h300); tick();
    update_pc[1] = 1; update_pc[3] = 1; tick();
    for (int k = 0; k < 4; k++) begin
      update_pc[1] = 1; update_pc[3] = k[0]; tick();
    end
    check("indep_ch1", pc_of(1), 'h204);
    check("indep_ch3", pc_of(3), 'h302);
    check("indep_ch2_idle", busy[2], 0);

    // Reset in the middle of a loop clears counters too
    set_load(1, 3); tick();
    update_pc[1] = 1; loop_back[1] = 1; set_target(1, 'h1F0); tick();
    rst = 1; tick();
    check("midloop_rst_pc", pc, 0);
    check("midloop_rst_busy", busy, 0);
    set_start(1, 'h050); tick();
    update_pc[1] = 1; tick();
    update_pc[1] = 1; loop_back[1] = 1; set_target(1, 'h010); tick();
    check("rst_cnt_zero_pc", pc_of(1), 'h051);
    check("rst_cnt_zero_done", loop_done[1], 1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < NCH; c++) begin
        start[c]     = ($urandom_range(0, 19) == 0);
        halt[c]      = ($urandom_range(0, 24) == 0);
        update_pc[c] = ($urandom_range(0, 1) == 1);
        jump_en[c]   = ($urandom_range(0, 7) == 0);
        loop_back[c] = ($urandom_range(0, 3) == 0);
        loop_load[c] = ($urandom_range(0, 11) == 0);
        loop_count[c*LW +: LW] = LW'($urandom_range(0, 3));
        target_pc[c*PCW +: PCW] = ($urandom_range(0, 3) == 0) ?
            PCW'(11'h7F8 + $urandom_range(0, 7)) : PCW'($urandom_range(0, PC_MOD - 1));
        start_pc[c*PCW +: PCW] = ($urandom_range(0, 2) == 0) ?
            PCW'(11'h7F0 + $urandom_range(0, 15)) : PCW'($urandom_range(0, PC_MOD - 1));
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_drive_pc_seq
`default_nettype wire
